// File: rtl/fd_dx_pipe_ctrl_pkg.sv
// Shared encodings for the F/D + D/X pipeline controller: opcode fields,
// the bubble instruction, controller states and the mul/div decode.
package fd_dx_pipe_ctrl_pkg;

    localparam logic [4:0] OP_ALU = 5'b00000;
    localparam logic [4:0] OP_LW  = 5'b01000;
    localparam logic [4:0] OP_SW  = 5'b00111;

    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;

    localparam logic [31:0] NOP_INSN = 32'h0000_0000;

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } pipe_state_e;

    // ALU-class instruction whose function field selects the multdiv unit
    function automatic logic is_muldiv(input logic [31:0] ir);
        return (ir[31:27] == OP_ALU) &&
               ((ir[6:2] == ALU_MUL) || (ir[6:2] == ALU_DIV));
    endfunction

endpackage

// File: rtl/fd_dx_pipe_ctrl_md_timeout_counter.sv
// Saturating wait counter for the multdiv interlock; tc flags the last
// cycle the controller is allowed to wait for md_ready.
module md_timeout_counter #(
    parameter int MD_TIMEOUT = 64,
    localparam int CW = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    logic [CW-1:0] count_reg;

    assign tc = (count_reg == CW'(MD_TIMEOUT - 1));

    // Holds at terminal count so the value never wraps
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && !tc) begin
            count_reg <= count_reg + CW'(1);
        end
    end

endmodule

// File: rtl/fd_dx_pipe_ctrl.sv
// Owns the F/D and D/X pipeline registers and applies load-use stalls,
// branch flushes and the multdiv interlock; drives pc_en and md_start.
module fd_dx_pipe_ctrl
    import fd_dx_pipe_ctrl_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] NOP        = WIDTH'(NOP_INSN),
    parameter int               MD_TIMEOUT = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] pc_f,
    input  logic [WIDTH-1:0] ir_f,
    input  logic             load_use_stall,
    input  logic             branch_taken,
    input  logic             md_ready,
    output logic             pc_en,
    output logic [WIDTH-1:0] pc_fd,
    output logic [WIDTH-1:0] ir_fd,
    output logic [WIDTH-1:0] pc_dx,
    output logic [WIDTH-1:0] ir_dx,
    output logic             md_start,
    output logic             md_busy,
    output logic             md_timeout
);

    pipe_state_e      state_reg, state_next;
    logic [WIDTH-1:0] pc_fd_reg, pc_fd_next;
    logic [WIDTH-1:0] ir_fd_reg, ir_fd_next;
    logic [WIDTH-1:0] pc_dx_reg, pc_dx_next;
    logic [WIDTH-1:0] ir_dx_reg, ir_dx_next;
    logic             md_timeout_reg, md_timeout_next;

    logic pc_en_comb;
    logic md_start_comb;
    logic cnt_clear;
    logic cnt_en;
    logic cnt_tc;
    logic dx_is_md;

    assign dx_is_md = is_muldiv(ir_dx_reg[31:0]);

    md_timeout_counter #(
        .MD_TIMEOUT(MD_TIMEOUT)
    ) u_md_timeout_counter (
        .clock (clock),
        .reset (reset),
        .clear (cnt_clear),
        .enable(cnt_en),
        .tc    (cnt_tc)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg      <= RUN;
            pc_fd_reg      <= '0;
            ir_fd_reg      <= NOP;
            pc_dx_reg      <= '0;
            ir_dx_reg      <= NOP;
            md_timeout_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pc_fd_reg      <= pc_fd_next;
            ir_fd_reg      <= ir_fd_next;
            pc_dx_reg      <= pc_dx_next;
            ir_dx_reg      <= ir_dx_next;
            md_timeout_reg <= md_timeout_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        pc_fd_next      = pc_fd_reg;
        ir_fd_next      = ir_fd_reg;
        pc_dx_next      = pc_dx_reg;
        ir_dx_next      = ir_dx_reg;
        md_timeout_next = md_timeout_reg;
        pc_en_comb      = 1'b0;
        md_start_comb   = 1'b0;
        cnt_clear       = 1'b0;
        cnt_en          = 1'b0;

        case (state_reg)
            RUN: begin
                if (branch_taken) begin
                    pc_fd_next = '0;
                    ir_fd_next = NOP;
                    pc_dx_next = '0;
                    ir_dx_next = NOP;
                    pc_en_comb = 1'b1;
                end else if (dx_is_md) begin
                    // Launch once; D/X is guaranteed to change before RUN resumes
                    md_start_comb = 1'b1;
                    cnt_clear     = 1'b1;
                    state_next    = MD_WAIT;
                end else if (load_use_stall) begin
                    pc_dx_next = '0;
                    ir_dx_next = NOP;
                end else begin
                    pc_fd_next = pc_f;
                    ir_fd_next = ir_f;
                    pc_dx_next = pc_fd_reg;
                    ir_dx_next = ir_fd_reg;
                    pc_en_comb = 1'b1;
                end
            end

            MD_WAIT: begin
                if (md_ready) begin
                    cnt_clear  = 1'b1;
                    state_next = RUN;
                    if (load_use_stall) begin
                        pc_dx_next = '0;
                        ir_dx_next = NOP;
                    end else begin
                        pc_fd_next = pc_f;
                        ir_fd_next = ir_f;
                        pc_dx_next = pc_fd_reg;
                        ir_dx_next = ir_fd_reg;
                        pc_en_comb = 1'b1;
                    end
                end else if (cnt_tc) begin
                    // Abandon the operation: bubble D/X so it cannot relaunch
                    md_timeout_next = 1'b1;
                    pc_dx_next      = '0;
                    ir_dx_next      = NOP;
                    cnt_clear       = 1'b1;
                    state_next      = RUN;
                end else begin
                    cnt_en = 1'b1;
                end
            end

            default: begin
                state_next = RUN;
            end
        endcase
    end

    assign pc_en      = pc_en_comb & reset;
    assign md_start   = md_start_comb & reset;
    assign md_busy    = (state_reg == MD_WAIT);
    assign md_timeout = md_timeout_reg;
    assign pc_fd      = pc_fd_reg;
    assign ir_fd      = ir_fd_reg;
    assign pc_dx      = pc_dx_reg;
    assign ir_dx      = ir_dx_reg;

endmodule

// File: tb/tb_fd_dx_pipe_ctrl.sv
// Directed plus randomized bench for fd_dx_pipe_ctrl against a
// cycle-level behavioural model of the pipeline hazard rules.
module tb_fd_dx_pipe_ctrl;

    localparam int MD_TO = 64;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_f, ir_f;
    logic        load_use_stall, branch_taken, md_ready;
    logic        pc_en, md_start, md_busy, md_timeout;
    logic [31:0] pc_fd, ir_fd, pc_dx, ir_dx;

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;
    bit check_en = 0;

    fd_dx_pipe_ctrl #(
        .WIDTH     (32),
        .NOP       (32'h0000_0000),
        .MD_TIMEOUT(MD_TO)
    ) dut (
        .clock         (clk),
        .reset         (rst_n),
        .pc_f          (pc_f),
        .ir_f          (ir_f),
        .load_use_stall(load_use_stall),
        .branch_taken  (branch_taken),
        .md_ready      (md_ready),
        .pc_en         (pc_en),
        .pc_fd         (pc_fd),
        .ir_fd         (ir_fd),
        .pc_dx         (pc_dx),
        .ir_dx         (ir_dx),
        .md_start      (md_start),
        .md_busy       (md_busy),
        .md_timeout    (md_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: pipeline contents plus "waiting for multdiv" and
    // how many wait cycles have elapsed.
    logic [31:0] m_pc_fd, m_ir_fd, m_pc_dx, m_ir_dx;
    bit          m_wait;
    int          m_waited;
    bit          m_to;

    function automatic bit m_muldiv(input logic [31:0] ir);
        return (ir[31:27] == 5'd0) && (ir[6:2] == 5'd6 || ir[6:2] == 5'd7);
    endfunction

    function automatic bit m_pc_en();
        if (!rst_n) return 1'b0;
        if (!m_wait) return branch_taken || (!m_muldiv(m_ir_dx) && !load_use_stall);
        return md_ready && !load_use_stall;
    endfunction

    function automatic bit m_md_start();
        return rst_n && !m_wait && !branch_taken && m_muldiv(m_ir_dx);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc_fd = 0; m_ir_fd = 0; m_pc_dx = 0; m_ir_dx = 0;
            m_wait = 0; m_waited = 0; m_to = 0;
        end else if (!m_wait) begin
            if (branch_taken) begin
                m_pc_fd = 0; m_ir_fd = 0; m_pc_dx = 0; m_ir_dx = 0;
            end else if (m_muldiv(m_ir_dx)) begin
                m_wait = 1; m_waited = 0;
            end else if (load_use_stall) begin
                m_pc_dx = 0; m_ir_dx = 0;
            end else begin
                m_pc_dx = m_pc_fd; m_ir_dx = m_ir_fd;
                m_pc_fd = pc_f;    m_ir_fd = ir_f;
            end
        end else begin
            m_waited++;
            if (md_ready) begin
                m_wait = 0;
                if (load_use_stall) begin
                    m_pc_dx = 0; m_ir_dx = 0;
                end else begin
                    m_pc_dx = m_pc_fd; m_ir_dx = m_ir_fd;
                    m_pc_fd = pc_f;    m_ir_fd = ir_f;
                end
            end else if (m_waited == MD_TO) begin
                m_to = 1; m_wait = 0;
                m_pc_dx = 0; m_ir_dx = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at t=%0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    // Compare process: every cycle, DUT against the model
    always @(negedge clk) begin
        if (check_en) begin
            chk("m_pc_en",    {31'd0, pc_en},      {31'd0, m_pc_en()});
            chk("m_md_start", {31'd0, md_start},   {31'd0, m_md_start()});
            chk("m_md_busy",  {31'd0, md_busy},    {31'd0, m_wait});
            chk("m_md_to",    {31'd0, md_timeout}, {31'd0, m_to});
            chk("m_pc_fd", pc_fd, m_pc_fd);
            chk("m_ir_fd", ir_fd, m_ir_fd);
            chk("m_pc_dx", pc_dx, m_pc_dx);
            chk("m_ir_dx", ir_dx, m_ir_dx);
        end
    end

    task automatic drive(input logic [31:0] pc, input logic [31:0] ir,
                         input logic st, input logic br, input logic rd);
        @(posedge clk); #1;
        pc_f = pc; ir_f = ir; load_use_stall = st; branch_taken = br; md_ready = rd;
        @(negedge clk); #1;
        cyc_n++;
        $display("cyc %0d pc_f=%h ir_f=%h st=%0b br=%0b rdy=%0b | pc_en=%0b start=%0b busy=%0b to=%0b fd=%h/%h dx=%h/%h",
                 cyc_n, pc, ir, st, br, rd, pc_en, md_start, md_busy, md_timeout,
                 pc_fd, ir_fd, pc_dx, ir_dx);
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        chk(name, {31'd0, act}, {31'd0, exp});
    endtask

    task automatic chk_reset_vals(input string tag);
        chk_bit({tag, "_pc_en"}, pc_en, 1'b0);
        chk_bit({tag, "_start"}, md_start, 1'b0);
        chk_bit({tag, "_busy"}, md_busy, 1'b0);
        chk_bit({tag, "_to"}, md_timeout, 1'b0);
        chk({tag, "_ir_fd"}, ir_fd, 32'h0);
        chk({tag, "_ir_dx"}, ir_dx, 32'h0);
        chk({tag, "_pc_fd"}, pc_fd, 32'h0);
        chk({tag, "_pc_dx"}, pc_dx, 32'h0);
    endtask

    initial begin
        rst_n = 1'b1;
        pc_f = 0; ir_f = 0; load_use_stall = 0; branch_taken = 1; md_ready = 0;
        #2 rst_n = 1'b0;
        #1 check_en = 1;
        @(posedge clk); #3;
        chk_reset_vals("L_rst");
        branch_taken = 0;
        rst_n = 1'b1;

        // Three normal fetches
        drive(0, 32'h11111111, 0, 0, 0);
        chk_bit("L_f0_pc_en", pc_en, 1'b1);
        drive(1, 32'h22222222, 0, 0, 0);
        chk_bit("L_f1_pc_en", pc_en, 1'b1);
        chk("L_f1_ir_fd", ir_fd, 32'h11111111);
        // Load-use stall while F/D holds 0x22222222
        drive(2, 32'h33333333, 1, 0, 0);
        chk("L_f2_ir_dx", ir_dx, 32'h11111111);
        chk("L_st_ir_fd", ir_fd, 32'h22222222);
        chk_bit("L_st_pc_en", pc_en, 1'b0);
        drive(2, 32'h33333333, 0, 0, 0);
        chk("L_st1_ir_fd", ir_fd, 32'h22222222);
        chk("L_st1_ir_dx", ir_dx, 32'h0);
        chk_bit("L_st1_pc_en", pc_en, 1'b1);
        drive(3, 32'h44444444, 0, 0, 0);
        chk("L_res_ir_dx", ir_dx, 32'h22222222);

        // Flush wins over stall
        drive(4, 32'h55555555, 1, 1, 0);
        chk_bit("L_bs_pc_en", pc_en, 1'b1);
        drive(5, 32'h66666666, 0, 0, 0);
        chk("L_bs_ir_fd", ir_fd, 32'h0);
        chk("L_bs_ir_dx", ir_dx, 32'h0);
        chk("L_bs_pc_fd", pc_fd, 32'h0);

        // mul reaches D/X, ready in the fifth wait cycle
        drive(6, 32'h00000018, 0, 0, 0);
        drive(7, 32'h77777777, 0, 0, 0);
        drive(8, 32'h88888888, 0, 0, 0);
        chk("L_mul_ir_dx", ir_dx, 32'h00000018);
        chk_bit("L_mul_start", md_start, 1'b1);
        chk_bit("L_mul_pc_en", pc_en, 1'b0);
        chk_bit("L_mul_busy0", md_busy, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(8, 32'h88888888, 0, 0, (i == 4));
            chk_bit("L_mw_busy", md_busy, 1'b1);
            chk_bit("L_mw_start", md_start, 1'b0);
            chk_bit("L_mw_pc_en", pc_en, (i == 4));
            chk("L_mw_ir_dx", ir_dx, 32'h00000018);
        end
        drive(9, 32'h0000001C, 0, 0, 0);
        chk_bit("L_mr_busy", md_busy, 1'b0);
        chk_bit("L_mr_start", md_start, 1'b0);
        chk("L_mr_ir_dx", ir_dx, 32'h77777777);
        chk("L_mr_ir_fd", ir_fd, 32'h88888888);

        // div with md_ready never asserted; branch ignored while waiting
        drive(10, 32'hAAAAAAAA, 0, 0, 0);
        drive(11, 32'hBBBBBBBB, 0, 0, 0);
        chk("L_div_ir_dx", ir_dx, 32'h0000001C);
        chk_bit("L_div_start", md_start, 1'b1);
        for (int i = 0; i < MD_TO; i++) begin
            drive(11, 32'hBBBBBBBB, 0, (i == 10), 0);
            chk_bit("L_to_busy", md_busy, 1'b1);
            chk_bit("L_to_flag0", md_timeout, 1'b0);
            chk("L_to_ir_dx", ir_dx, 32'h0000001C);
        end
        drive(11, 32'hBBBBBBBB, 0, 0, 0);
        chk_bit("L_to_flag", md_timeout, 1'b1);
        chk_bit("L_to_busy1", md_busy, 1'b0);
        chk("L_to_dx_nop", ir_dx, 32'h0);
        chk("L_to_ir_fd", ir_fd, 32'hAAAAAAAA);
        chk_bit("L_to_pc_en", pc_en, 1'b1);
        drive(12, 32'h12345670, 0, 0, 0);
        drive(13, 32'h23456780, 0, 0, 0);
        chk_bit("L_to_sticky", md_timeout, 1'b1);

        // Reset in the middle of a wait
        drive(14, 32'h00000018, 0, 0, 0);
        drive(15, 32'h12345670, 0, 0, 0);
        drive(16, 32'h23456780, 0, 0, 0);
        chk_bit("L_rw_start", md_start, 1'b1);
        drive(16, 32'h23456780, 0, 0, 0);
        chk_bit("L_rw_busy", md_busy, 1'b1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("L_rw");
        @(posedge clk); #3;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(32'(17 + i), 32'h31000000 + 32'(i), 0, 0, 0);
            chk_bit("L_post_start", md_start, 1'b0);
        end

        // Randomized traffic checked by the model
        for (int i = 0; i < 500; i++) begin
            logic [31:0] ir;
            int r;
            r  = $urandom_range(0, 7);
            ir = $urandom;
            if (r < 2) begin
                ir[31:27] = 5'd0;
                ir[6:2]   = (r == 0) ? 5'd6 : 5'd7;
            end
            drive($urandom, ir, ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
        end

        check_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fd_dx_pipe_ctrl.md
Name: fd_dx_pipe_ctrl

Overview:
- Responder side of the pipeline hazard interface. Owns the F/D and D/X pipeline registers (PC + instruction each).
- Applies the hazard requests that arrive from outside this block:
  - load-use stall from the hazard detector;
  - branch flush from the execute stage;
  - multiply/divide interlock with the multdiv unit.
- Sits between fetch and execute in the 5-stage core.
- Produces the PC write enable and the multdiv start handshake.

Parameters:
- WIDTH, 32, instruction/PC width.
- NOP, 32'h00000000, bubble instruction inserted on stall/flush.
- MD_TIMEOUT, 64, max cycles waited for md_ready before abort.

Ports:
- clock  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- pc_f  in  WIDTH  PC of instruction being fetched.
- ir_f  in  WIDTH  instruction being fetched.
- load_use_stall  in  1  hazard detector request: hold PC and F/D, bubble D/X.
- branch_taken  in  1  execute-stage redirect: flush F/D and D/X.
- md_ready  in  1  multdiv result valid (1-cycle pulse).
- pc_en  out  1  PC register write enable (combinational).
- pc_fd, ir_fd  out  WIDTH  F/D register contents.
- pc_dx, ir_dx  out  WIDTH  D/X register contents.
- md_start  out  1  1-cycle pulse starting multdiv (combinational).
- md_busy  out  1  high while in MD_WAIT (registered).
- md_timeout  out  1  sticky abort flag (registered).

Behaviour:
- Reset (reset=0, async):
  - ir_fd=ir_dx=NOP; pc_fd=pc_dx=0.
  - State RUN; counter 0; md_busy=0; md_timeout=0.
  - pc_en=0 and md_start=0 while reset is low.
- mul/div detect:
  - ir_dx[31:27]==5'b00000 and ir_dx[6:2] is 5'b00110 (mul) or 5'b00111 (div).
- State RUN, per cycle, priority order (highest first):
  1. branch_taken: ir_fd<=NOP, ir_dx<=NOP (PCs <=0); pc_en=1; md_start=0.
  2. mul/div in D/X: md_start=1 this cycle; pc_en=0; F/D and D/X hold; next state MD_WAIT; counter<=0.
  3. load_use_stall: pc_en=0; F/D hold; D/X<=NOP (pc_dx<=0).
  4. normal: F/D<={pc_f,ir_f}; D/X<=F/D; pc_en=1.
- State MD_WAIT (md_busy=1):
  - branch_taken is ignored; md_start=0.
  - Each cycle without md_ready:
    - pc_en=0; everything holds; counter increments.
    - When counter reaches MD_TIMEOUT-1: md_timeout<=1 (sticky), D/X<=NOP, F/D holds, pc_en=0, go RUN.
  - md_ready=1: D/X advances; next state RUN; counter<=0.
    - If load_use_stall also high: pc_en=0, F/D hold, D/X<=NOP.
    - Otherwise: pc_en=1, F/D<={pc_f,ir_f}, D/X<=F/D.
- md_start never re-fires for the same instruction. D/X always changes on leaving MD_WAIT.
- Counter width is clog2(MD_TIMEOUT); it never wraps.
- Reset asserted mid-MD_WAIT: immediate return to the reset values; md_timeout cleared.
- Simultaneous branch_taken and load_use_stall in RUN: flush wins, pc_en=1.

Decomposition:
- Shared package holds:
  - opcode constants: OP_ALU=00000, OP_LW=01000, OP_SW=00111;
  - ALU op constants: ALU_MUL=00110, ALU_DIV=00111;
  - the NOP encoding;
  - the state enum {RUN, MD_WAIT}.
- One sub-module: md_timeout_counter (clear, enable, terminal-count output, async active-low reset).

Test Plan:
- Reset then 3 normal fetches:
  - Stimulus: ir_f=0x11111111/0x22222222/0x33333333 at pc 0,1,2.
  - Response: ir_dx=0x11111111 two cycles after first fetch; pc_en=1 throughout.
- load_use_stall for 1 cycle with ir_fd=0x22222222:
  - Response: pc_en=0 that cycle, ir_fd stays 0x22222222, ir_dx becomes NOP, then normal flow resumes.
- branch_taken together with load_use_stall:
  - Response: ir_fd=ir_dx=NOP next cycle, pc_en=1.
- mul in D/X (ir_dx=0x00000018), md_ready after 5 cycles:
  - md_start high exactly 1 cycle, md_busy high 5 cycles, pc_en=0 during the wait.
  - After ready: D/X=prior ir_fd; md_start stays 0.
- mul in D/X with md_ready never asserted (MD_TIMEOUT=64):
  - md_timeout=1 after 64 cycles, ir_dx=NOP, state RUN, flag stays set until reset.
- reset pulled low during MD_WAIT:
  - All outputs return to reset values asynchronously; no md_start after release until a new mul/div is in D/X.
